// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ifu_fetch -- instruction fetch unit with a small in-order fetch queue.
//
// Fetches sequential 32-bit words from an instruction memory that answers
// combinationally in the request cycle, buffers {pc, insn} pairs in a FIFO
// and presents the oldest entry downstream with a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at a new address.
//
// Optional feature (macro IFU_MISALIGN_CHECK_EN):
//   defined   - a redirect to a non word-aligned address parks the unit in
//               FAULT (o_fetch_fault=1, no fetches) until an aligned redirect
//               or reset.
//   undefined - redirect address bits [1:0] are ignored; o_fetch_fault is 0.
//
// Parameters:
//   RESET_VECTOR    first fetch address after reset
//   FIFO_DEPTH      fetch-queue entries (power of two, >= 2)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   o_ic_pc, o_ic_en         fetch address and request strobe
//   i_ic_insn, i_ic_valid    returned instruction word and its valid
//   i_redirect(_addr)        flush and restart fetch at a new address
//   o_insn, o_pc, o_valid    queue head; popped when o_valid && i_ready
//   i_ready                  downstream accepts the head
//   o_fetch_fault            misaligned-redirect fault indication
module ifu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_ic_pc,
    output logic        o_ic_en,
    input  logic [31:0] i_ic_insn,
    input  logic        i_ic_valid,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    output logic [31:0] o_insn,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {INIT, FETCH, FULL, FAULT} state_t;

    state_t             state, state_d;
    logic [31:0]        pc, pc_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_d;
    logic               push, pop;
    logic               redir_misaligned;
    logic [31:0]        redir_pc;

    logic [31:0]        q_pc   [FIFO_DEPTH];
    logic [31:0]        q_insn [FIFO_DEPTH];

    // The stored address is always word aligned; the low bits only matter
    // for deciding whether a fault is raised.
    assign redir_pc = i_redirect_addr & 32'hFFFF_FFFC;
`ifdef IFU_MISALIGN_CHECK_EN
    assign redir_misaligned = (i_redirect_addr[1:0] != 2'b00);
    assign o_fetch_fault    = (state == FAULT);
`else
    assign redir_misaligned = 1'b0;
    assign o_fetch_fault    = 1'b0;
`endif

    // Head of queue is a combinational read of registered storage, so it is
    // stable while the head is not popped. Zeroed when empty so nothing stale
    // leaks out after reset or a flush.
    assign o_valid = (count != '0);
    assign o_pc    = o_valid ? q_pc[rd_ptr]   : 32'h0;
    assign o_insn  = o_valid ? q_insn[rd_ptr] : 32'h0;
    assign o_ic_pc = pc;

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        count_d  = count;
        rd_ptr_d = rd_ptr;
        wr_ptr_d = wr_ptr;
        // Fetch eligibility uses the registered count only: a pop in this
        // cycle frees a slot for the next cycle, not this one. A redirect
        // suppresses the request in its own cycle.
        o_ic_en  = (state == FETCH) && (count < DEPTH_C) && !i_redirect;
        push     = o_ic_en && i_ic_valid;
        pop      = o_valid && i_ready && !i_redirect;

        if (i_redirect) begin
            pc_d     = redir_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = redir_misaligned ? FAULT : FETCH;
        end else begin
            if (push) begin
                pc_d     = pc + 32'd4;
                wr_ptr_d = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count + CNT_W'(1);
                2'b01:   count_d = count - CNT_W'(1);
                default: count_d = count;
            endcase
            case (state)
                INIT:        state_d = FETCH;
                FETCH, FULL: state_d = (count_d == DEPTH_C) ? FULL : FETCH;
                FAULT:       state_d = FAULT;
                default:     state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            pc     <= RESET_VECTOR;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            count  <= count_d;
            rd_ptr <= rd_ptr_d;
            wr_ptr <= wr_ptr_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_pc[wr_ptr]   <= pc;
            q_insn[wr_ptr] <= i_ic_insn;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] o_ic_pc;
    logic        o_ic_en;
    logic [31:0] i_ic_insn;
    logic        i_ic_valid;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic [31:0] o_insn;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic        o_fetch_fault;

    int checks   = 0;
    int passed   = 0;
    int push_cnt = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_e;

    ifu_fetch #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .o_ic_pc(o_ic_pc), .o_ic_en(o_ic_en),
        .i_ic_insn(i_ic_insn), .i_ic_valid(i_ic_valid),
        .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
        .o_insn(o_insn), .o_pc(o_pc), .o_valid(o_valid),
        .i_ready(i_ready), .o_fetch_fault(o_fetch_fault)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign i_ic_insn = rom_word(o_ic_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: accepted fetches are queued, popped entries are compared.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            checks++;
            if (o_valid !== (sb.size() != 0)) $display("FAIL sb_valid: got %b want %b", o_valid, (sb.size() != 0));
            else passed++;
            if (i_redirect) begin
                sb.delete();
            end else begin
                if (o_valid === 1'b1 && i_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_pop: got pc=%h with empty scoreboard", o_pc);
                    end else begin
                        exp_e = sb.pop_front();
                        if ({o_pc, o_insn} !== exp_e) $display("FAIL sb_head: got %h/%h want %h/%h", o_pc, o_insn, exp_e[63:32], exp_e[31:0]);
                        else passed++;
                    end
                end
                if (o_ic_en === 1'b1 && i_ic_valid) begin
                    sb.push_back({o_ic_pc, rom_word(o_ic_pc)});
                    push_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; i_redirect = 1'b0; i_ic_valid = 1'b1; i_ready = rdy;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; push_cnt = 0;
    endtask

    task automatic test_reset();
        // reset asserted together with a redirect: reset must win
        rst = 1'b1; i_redirect = 1'b1; i_redirect_addr = 32'h300; i_ready = 1'b1; i_ic_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (o_ic_en !== 1'b0) $display("FAIL rst_ic_en: got %b want 0", o_ic_en); else passed++;
        checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_valid); else passed++;
        checks++; if (o_fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", o_fetch_fault); else passed++;
        checks++; if (o_insn !== 32'h0) $display("FAIL rst_insn: got %h want 0", o_insn); else passed++;
        checks++; if (o_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", o_pc); else passed++;
        tick(); rst = 1'b0; i_redirect = 1'b0; push_cnt = 0;
        @(negedge clk);
        checks++; if (o_ic_en !== 1'b0) $display("FAIL init_ic_en: got %b want 0", o_ic_en); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_en !== 1'b1) $display("FAIL c2_ic_en: got %b want 1", o_ic_en); else passed++;
        checks++; if (o_ic_pc !== 32'h0) $display("FAIL c2_ic_pc: got %h want 0", o_ic_pc); else passed++;
        checks++; if (o_valid !== 1'b0) $display("FAIL c2_valid: got %b want 0", o_valid); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h4) $display("FAIL c3_ic_pc: got %h want 4", o_ic_pc); else passed++;
        checks++; if (o_valid !== 1'b1) $display("FAIL c3_valid: got %b want 1", o_valid); else passed++;
        checks++; if (o_pc !== 32'h0) $display("FAIL c3_pc: got %h want 0", o_pc); else passed++;
        checks++; if (o_insn !== rom_word(32'h0)) $display("FAIL c3_insn: got %h want %h", o_insn, rom_word(32'h0)); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h8) $display("FAIL c4_ic_pc: got %h want 8", o_ic_pc); else passed++;
        checks++; if (o_pc !== 32'h4) $display("FAIL c4_pc: got %h want 4", o_pc); else passed++;
    endtask

    task automatic test_full();
        do_reset(1'b0);
        repeat (6) tick();
        @(negedge clk);
        checks++; if (push_cnt != 4) $display("FAIL full_pushes: got %0d want 4", push_cnt); else passed++;
        checks++; if (o_ic_en !== 1'b0) $display("FAIL full_ic_en: got %b want 0", o_ic_en); else passed++;
        checks++; if (o_ic_pc !== 32'h10) $display("FAIL full_ic_pc: got %h want 10", o_ic_pc); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk);
            checks++; if (o_pc !== 32'h0 || o_insn !== rom_word(32'h0)) $display("FAIL full_hold: got %h/%h want 0/%h", o_pc, o_insn, rom_word(32'h0)); else passed++;
            checks++; if (o_ic_en !== 1'b0) $display("FAIL full_hold_en: got %b want 0", o_ic_en); else passed++;
        end
        tick(); i_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_ic_en !== 1'b0) $display("FAIL pop_cycle_en: got %b want 0", o_ic_en); else passed++;
        tick(); i_ready = 1'b0;
        @(negedge clk);
        checks++; if (o_ic_en !== 1'b1) $display("FAIL refetch_en: got %b want 1", o_ic_en); else passed++;
        checks++; if (o_ic_pc !== 32'h10) $display("FAIL refetch_pc: got %h want 10", o_ic_pc); else passed++;
        checks++; if (o_pc !== 32'h4) $display("FAIL refetch_head: got %h want 4", o_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_en !== 1'b0) $display("FAIL refull_en: got %b want 0", o_ic_en); else passed++;
        checks++; if (push_cnt != 5) $display("FAIL refull_pushes: got %0d want 5", push_cnt); else passed++;
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        tick(); tick(); tick();
        i_ic_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_ic_pc !== 32'h8 || o_ic_en !== 1'b1) $display("FAIL stall0: got %h/%b want 8/1", o_ic_pc, o_ic_en); else passed++;
        checks++; if (push_cnt != 2) $display("FAIL stall0_pushes: got %0d want 2", push_cnt); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h8) $display("FAIL stall1: got %h want 8", o_ic_pc); else passed++;
        tick(); i_ic_valid = 1'b1;
        @(negedge clk);
        checks++; if (o_ic_pc !== 32'h8) $display("FAIL resume8: got %h want 8", o_ic_pc); else passed++;
        checks++; if (push_cnt != 2) $display("FAIL stall_pushes: got %0d want 2", push_cnt); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'hC) $display("FAIL resume12: got %h want c", o_ic_pc); else passed++;
        checks++; if (push_cnt != 3) $display("FAIL resume_pushes: got %0d want 3", push_cnt); else passed++;
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (4) tick();
        i_redirect = 1'b1; i_redirect_addr = 32'h100; i_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_ic_en !== 1'b0) $display("FAIL redir_en: got %b want 0", o_ic_en); else passed++;
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) $display("FAIL redir_head: got %b/%h want 1/0", o_valid, o_pc); else passed++;
        tick(); i_redirect = 1'b0;
        @(negedge clk);
        checks++; if (o_valid !== 1'b0) $display("FAIL post_redir_valid: got %b want 0", o_valid); else passed++;
        checks++; if (o_ic_en !== 1'b1 || o_ic_pc !== 32'h100) $display("FAIL post_redir_fetch: got %b/%h want 1/100", o_ic_en, o_ic_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_pc !== 32'h100 || o_insn !== rom_word(32'h100)) $display("FAIL redir_head2: got %h/%h want 100/%h", o_pc, o_insn, rom_word(32'h100)); else passed++;
        checks++; if (o_ic_pc !== 32'h104) $display("FAIL redir_next: got %h want 104", o_ic_pc); else passed++;
    endtask

    task automatic test_wrap();
        i_ready = 1'b1;
        tick(); i_redirect = 1'b1; i_redirect_addr = 32'hFFFF_FFF8;
        tick(); i_redirect = 1'b0;
        @(negedge clk);
        checks++; if (o_ic_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_a: got %h want fffffff8", o_ic_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_b: got %h want fffffffc", o_ic_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h0) $display("FAIL wrap_c: got %h want 0", o_ic_pc); else passed++;
        checks++; if (o_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_head: got %h want fffffffc", o_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h4) $display("FAIL wrap_d: got %h want 4", o_ic_pc); else passed++;
    endtask

    task automatic test_misalign();
        tick(); i_redirect = 1'b1; i_redirect_addr = 32'h102;
        tick(); i_redirect = 1'b0;
        @(negedge clk);
`ifdef IFU_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_fetch_fault !== 1'b1 || o_ic_en !== 1'b0) $display("FAIL fault_hold: got %b/%b want 1/0", o_fetch_fault, o_ic_en); else passed++;
            tick(); @(negedge clk);
        end
        i_redirect = 1'b1; i_redirect_addr = 32'h200;
        tick(); i_redirect = 1'b0;
        @(negedge clk);
        checks++; if (o_fetch_fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", o_fetch_fault); else passed++;
        checks++; if (o_ic_en !== 1'b1 || o_ic_pc !== 32'h200) $display("FAIL fault_refetch: got %b/%h want 1/200", o_ic_en, o_ic_pc); else passed++;
`else
        checks++; if (o_fetch_fault !== 1'b0) $display("FAIL nofault: got %b want 0", o_fetch_fault); else passed++;
        checks++; if (o_ic_en !== 1'b1 || o_ic_pc !== 32'h100) $display("FAIL align_fetch: got %b/%h want 1/100", o_ic_en, o_ic_pc); else passed++;
        tick(); @(negedge clk);
        checks++; if (o_ic_pc !== 32'h104 || o_pc !== 32'h100) $display("FAIL align_next: got %h/%h want 104/100", o_ic_pc, o_pc); else passed++;
`endif
    endtask

    initial begin
        rst = 1'b1; i_redirect = 1'b0; i_redirect_addr = 32'h0; i_ic_valid = 1'b1; i_ready = 1'b1;
        test_reset();
        test_full();
        test_stall();
        test_redirect();
        test_wrap();
        test_misalign();
        tick(); tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the fetch-queue entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port o_ic_pc  output  32  instruction fetch address to the instruction memory.
REQ-006 SHALL have port o_ic_en  output  1  fetch request strobe.
REQ-007 SHALL have port i_ic_insn  input  32  instruction word, little-endian, returned combinationally in the request cycle.
REQ-008 SHALL have port i_ic_valid  input  1  i_ic_insn holds valid data this cycle.
REQ-009 SHALL have port i_redirect  input  1  flush the queue and restart fetch.
REQ-010 SHALL have port i_redirect_addr  input  32  new fetch address.
REQ-011 SHALL have port o_insn  output  32  queue-head instruction.
REQ-012 SHALL have port o_pc  output  32  queue-head PC.
REQ-013 SHALL have port o_valid  output  1  queue head valid.
REQ-014 SHALL have port i_ready  input  1  downstream accepts head; pop when o_valid && i_ready.
REQ-015 SHALL have port o_fetch_fault  output  1  misaligned-redirect fault (see Configuration).

Function
REQ-016 SHALL implement FSM states INIT, FETCH, FULL, FAULT.
REQ-017 INIT SHALL last exactly one cycle after reset deassertion, then go to FETCH; o_ic_en=0 in INIT.
REQ-018 FETCH: o_ic_en=1, o_ic_pc=fetch PC register; combinational from registered state only.
REQ-019 On o_ic_en && i_ic_valid: SHALL push {PC, i_ic_insn} into the queue and advance PC by 4 (mod 2^32 wrap).
REQ-020 On o_ic_en && !i_ic_valid: SHALL push nothing and hold PC (retry same address next cycle).
REQ-021 Fetch SHALL be permitted only when registered count < FIFO_DEPTH; a same-cycle pop does not enable a fetch.
REQ-022 FETCH->FULL when a push makes count==FIFO_DEPTH without a pop; FULL->FETCH when count drops below FIFO_DEPTH; o_ic_en=0 in FULL.
REQ-023 Queue entry pushed in cycle N SHALL appear at o_valid/o_insn/o_pc no earlier than cycle N+1; order strictly FIFO.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 o_insn/o_pc SHALL be held stable while o_valid && !i_ready.
REQ-026 i_redirect SHALL take priority over push and pop that cycle: queue emptied, count=0, PC=i_redirect_addr, o_ic_en=0 that cycle, state->FETCH next cycle (or FAULT per REQ-031).
REQ-027 o_valid SHALL be 0 in the cycle after a redirect.

Reset
REQ-028 On rst: state=INIT, PC=RESET_VECTOR, count=0, pointers=0, o_ic_en=0, o_valid=0, o_fetch_fault=0, o_insn=0, o_pc=0.
REQ-029 rst SHALL override i_redirect and any in-progress fetch; queue contents discarded.

Configuration
REQ-030 Macro IFU_MISALIGN_CHECK_EN SHALL select redirect alignment handling.
REQ-031 Defined: redirect with i_redirect_addr[1:0]!=0 enters FAULT; o_fetch_fault=1, o_ic_en=0 until an aligned redirect (->FETCH, fault cleared) or reset.
REQ-032 Undefined: i_redirect_addr[1:0] forced to 2'b00; FAULT state unreachable; o_fetch_fault tied 0.

Verification
REQ-033 Reset, RESET_VECTOR=0, ROM words w0..w3, i_ready=1 -> o_ic_pc 0,4,8,... from cycle 2; o_valid first in cycle 3 with o_pc=0, o_insn=w0.
REQ-034 i_ready=0, FIFO_DEPTH=4 -> exactly 4 pushes (PC 0..12), state FULL, o_ic_en=0, head PC=0 held; i_ready=1 for one cycle -> one pop, one fetch of PC 16 the next cycle.
REQ-035 i_ic_valid=0 for 2 cycles at PC 8 -> PC holds 8, no pushes; resumes at 8 then 12.
REQ-036 Queue holding 3 entries, i_redirect=1 with addr 32'h100 and i_ready=1 -> no pop, o_valid=0 next cycle, next fetch at 32'h100.
REQ-037 PC=32'hFFFF_FFFC fetch -> next PC 32'h0000_0000.
REQ-038 Redirect to 32'h102: with IFU_MISALIGN_CHECK_EN o_fetch_fault=1, no fetches until redirect to 32'h200; without it fetch begins at 32'h100.
